fetch_queue_ctrl: RTL and testbench

//  Parametrised instruction-fetch front end for the custom processor core.

---
 rtl/fetch_queue_ctrl_pkg.sv | 19 +
 rtl/fetch_queue_ctrl_if.sv | 39 +++
 rtl/fetch_queue_ctrl_fifo.sv | 74 +++++++
 rtl/fetch_queue_ctrl.sv | 103 ++++++++++
 tb/tb_fetch_queue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_ctrl_pkg.sv
// Shared types for the instruction-fetch front end: default widths,
// the fetch FSM state and the queue entry layout.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_INSTR_W = 16;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // One prefetch queue entry: the fetched word together with its PC.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Bundle of fetch-unit signals: redirect/halt control, instruction-memory
// port and the decode-side instruction stream.
//
// Decode handshake: instr_valid/instr_out/instr_pc are driven by the fetch
// unit and held stable while instr_valid=1 and instr_ready=0. A transfer
// happens on every rising clk edge where instr_valid and instr_ready are both 1;
// instr_valid never depends combinationally on instr_ready.
interface fetch_queue_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 4
);
    logic                       jump_en;
    logic [ADDR_W-1:0]          jump_addr;
    logic                       halt;
    logic                       im_req;
    logic [ADDR_W-1:0]          im_addr;
    logic [INSTR_W-1:0]         im_rdata;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [INSTR_W-1:0]         instr_out;
    logic [ADDR_W-1:0]          instr_pc;
    logic [$clog2(DEPTH+1)-1:0] q_count;
    fetch_state_t               state_dbg;

    // Fetch-unit side.
    modport master (
        input  jump_en, jump_addr, halt, im_rdata, instr_ready,
        output im_req, im_addr, instr_valid, instr_out, instr_pc, q_count, state_dbg
    );

    // Environment side (core pipeline + instruction memory).
    modport slave (
        output jump_en, jump_addr, halt, im_rdata, instr_ready,
        input  im_req, im_addr, instr_valid, instr_out, instr_pc, q_count, state_dbg
    );
endinterface

// File: rtl/fetch_queue_ctrl_fifo.sv
// Synchronous prefetch FIFO. Pointers wrap naturally because DEPTH is a
// power of two; flush empties the queue and wins over push in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next-state for pointers and occupancy; a pop on an empty queue is ignored.
    always_comb begin
        do_push  = push & ~flush;
        do_pop   = pop & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // The issue credit check upstream must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(do_push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency reads,
// tags returning words with their PC and queues them for decode.
module fetch_queue_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstn,
    fetch_queue_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              issue, kill, push, pop;
    logic [CNT_W:0]    credit_used;
    logic [CNT_W-1:0]  count;
    entry_t            push_entry, head_entry;

    // Issue/credit logic and next PC. A read is only issued when the queue
    // has room for it plus the one already in flight, so a return can always
    // be pushed. The return that coincides with a redirect is stale and is
    // dropped (kill); the flush clears the queue in that same cycle.
    always_comb begin
        credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        issue       = rstn & (state_q == RUN) & ~bus.halt & ~bus.jump_en
                    & (credit_used < (CNT_W+1)'(DEPTH));
        kill        = bus.jump_en;
        push        = inflight_q & ~kill;
        pop         = (count != '0) & bus.instr_ready;
        push_entry.pc    = tag_q;
        push_entry.instr = bus.im_rdata;
        pc_d        = pc_q;
        tag_d       = tag_q;
        inflight_d  = issue;
        if (bus.jump_en) begin
            pc_d = bus.jump_addr;
        end else if (issue) begin
            pc_d  = pc_q + 1'b1;
            tag_d = pc_q;
        end
    end

    // PC, in-flight flag and tag of the outstanding read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            tag_q      <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    // Run/halt FSM; a redirect while halted does not change the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     if (bus.halt)  state_q <= HALTED;
                HALTED:  if (!bus.halt) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.jump_en),
        .head      (head_entry),
        .count     (count)
    );

    assign bus.im_req      = issue;
    assign bus.im_addr     = pc_q;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_out   = head_entry.instr;
    assign bus.instr_pc    = head_entry.pc;
    assign bus.q_count     = count;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: directed timing scenarios followed by random
// ready/halt/jump traffic, all checked against a queue-level reference model.
module tb_fetch_queue_ctrl;
    import fetch_pkg::*;

    localparam int         ADDR_W   = 8;
    localparam int         INSTR_W  = 16;
    localparam int         DEPTH    = 4;
    localparam logic [7:0] RESET_PC = 8'h00;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    fetch_queue_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    fetch_queue_ctrl #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [INSTR_W-1:0] rom [256];

    // Reference model state: expected queue contents (PCs), fetch PC, in-flight read.
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] m_fetch_pc;
    logic [ADDR_W-1:0] m_inflight_pc;
    logic              m_inflight;
    logic              m_prev_halt;
    logic              m_exp_req;
    logic              m_pop;
    logic [ADDR_W-1:0] last_pop_pc;
    logic              hs_seen;
    logic [ADDR_W-1:0] hs_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory: data for a read appears the cycle after im_req.
    initial begin
        logic              r;
        logic [ADDR_W-1:0] a;
        bus.im_rdata = '0;
        forever begin
            @(negedge clk);
            r = bus.im_req;
            a = bus.im_addr;
            @(posedge clk);
            #1;
            bus.im_rdata = r ? rom[a] : INSTR_W'($urandom);
        end
    end

    // Scoreboard: compare every cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        hs_seen = 1'b0;
        if (!rstn) begin
            check_eq("rst_im_req", 32'(bus.im_req), 32'd0);
            check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
            check_eq("rst_q_count", 32'(bus.q_count), 32'd0);
            check_eq("rst_im_addr", 32'(bus.im_addr), 32'(RESET_PC));
            exp_q.delete();
            m_fetch_pc  = RESET_PC;
            m_inflight  = 1'b0;
            m_prev_halt = 1'b0;
        end else begin
            m_exp_req = !bus.halt && !bus.jump_en && !m_prev_halt
                        && ((exp_q.size() + int'(m_inflight)) < DEPTH);
            check_eq("im_req", 32'(bus.im_req), 32'(m_exp_req));
            check_eq("im_addr", 32'(bus.im_addr), 32'(m_fetch_pc));
            check_eq("q_count", 32'(bus.q_count), 32'(exp_q.size()));
            check_eq("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
            m_pop = (exp_q.size() != 0) && bus.instr_ready;
            if (m_pop) begin
                check_eq("head_pc", 32'(bus.instr_pc), 32'(exp_q[0]));
                check_eq("head_instr", 32'(bus.instr_out), 32'(rom[exp_q[0]]));
                last_pop_pc = exp_q[0];
                hs_seen     = 1'b1;
                hs_pc       = bus.instr_pc;
                void'(exp_q.pop_front());
            end
            if (bus.jump_en) begin
                exp_q.delete();
                m_fetch_pc = bus.jump_addr;
                m_inflight = 1'b0;
            end else begin
                if (m_inflight) exp_q.push_back(m_inflight_pc);
                m_inflight = m_exp_req;
                if (m_exp_req) begin
                    m_inflight_pc = m_fetch_pc;
                    m_fetch_pc    = m_fetch_pc + 8'd1;
                end
            end
            m_prev_halt = bus.halt;
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        next_cycle();
        rstn = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = INSTR_W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        logic saw_ff;
        logic done;

        bus.jump_en     = 1'b0;
        bus.jump_addr   = '0;
        bus.halt        = 1'b0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = INSTR_W'(i);

        // 1: reset release, streaming at one instruction per cycle
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_eq("t1_req_c0", 32'(bus.im_req), 32'd1);
        check_eq("t1_valid_c0", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_valid_c1", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check_eq("t1_valid_c2", 32'(bus.instr_valid), 32'd1);
        check_eq("t1_out_c2", 32'(bus.instr_out), 32'd0);
        check_eq("t1_pc_c2", 32'(bus.instr_pc), 32'd0);
        @(negedge clk);
        check_eq("t1_out_c3", 32'(bus.instr_out), 32'd1);
        check_eq("t1_pc_c3", 32'(bus.instr_pc), 32'd1);
        repeat (20) @(negedge clk);

        // 2: backpressure saturates the queue, then drains without loss
        pulse_reset();
        repeat (5) next_cycle();
        bus.instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("t2_q_full", 32'(bus.q_count), 32'd4);
        check_eq("t2_req_off", 32'(bus.im_req), 32'd0);
        next_cycle();
        bus.instr_ready = 1'b1;
        repeat (15) @(negedge clk);

        // 3: redirect with 3 queued entries and a read in flight
        bus.instr_ready = 1'b0;
        pulse_reset();
        repeat (4) next_cycle();
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'h40;
        @(negedge clk);
        check_eq("t3_cnt_before", 32'(bus.q_count), 32'd3);
        check_eq("t3_req_n", 32'(bus.im_req), 32'd0);
        next_cycle();
        bus.jump_en     = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check_eq("t3_cnt_n1", 32'(bus.q_count), 32'd0);
        check_eq("t3_req_n1", 32'(bus.im_req), 32'd1);
        check_eq("t3_addr_n1", 32'(bus.im_addr), 32'h40);
        @(negedge clk);
        check_eq("t3_valid_n2", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check_eq("t3_valid_n3", 32'(bus.instr_valid), 32'd1);
        check_eq("t3_pc_n3", 32'(bus.instr_pc), 32'h40);
        repeat (10) @(negedge clk);

        // 4: redirect coinciding with a handshake, then back-to-back jumps
        next_cycle();
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'h10;
        @(negedge clk);
        check_eq("t4_hs_valid", 32'(bus.instr_valid), 32'd1);
        next_cycle();
        bus.jump_addr = 8'h20;
        @(negedge clk);
        check_eq("t4_req_n1", 32'(bus.im_req), 32'd0);
        next_cycle();
        bus.jump_en = 1'b0;
        @(negedge clk);
        check_eq("t4_addr_n2", 32'(bus.im_addr), 32'h20);
        check_eq("t4_valid_n2", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check_eq("t4_valid_n3", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check_eq("t4_valid_n4", 32'(bus.instr_valid), 32'd1);
        check_eq("t4_pc_n4", 32'(bus.instr_pc), 32'h20);
        repeat (5) @(negedge clk);

        // 5: halt with a full queue drains it; fetch resumes sequentially
        next_cycle();
        bus.instr_ready = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("t5_full", 32'(bus.q_count), 32'd4);
        next_cycle();
        bus.halt        = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("t5_req_halted", 32'(bus.im_req), 32'd0);
        end
        check_eq("t5_drained", 32'(bus.q_count), 32'd0);
        next_cycle();
        bus.halt = 1'b0;
        @(negedge clk);
        check_eq("t5_req_leave", 32'(bus.im_req), 32'd0);
        @(negedge clk);
        check_eq("t5_req_resume", 32'(bus.im_req), 32'd1);
        check_eq("t5_resume_addr", 32'(bus.im_addr), 32'(last_pop_pc + 8'd1));
        repeat (5) @(negedge clk);

        // 6: PC wrap 0xFF -> 0x00, then asynchronous reset mid-stream
        next_cycle();
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'hFC;
        next_cycle();
        bus.jump_en = 1'b0;
        saw_ff = 1'b0;
        done   = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            #1;
            if (hs_seen) begin
                if (saw_ff) begin
                    check_eq("t6_wrap_pc", 32'(hs_pc), 32'h00);
                    done = 1'b1;
                end else if (hs_pc == 8'hFF) begin
                    saw_ff = 1'b1;
                end
            end
        end
        if (!done) check_eq("t6_wrap_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check_eq("t6_valid_before", 32'(bus.instr_valid), 32'd1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_eq("t6_async_req", 32'(bus.im_req), 32'd0);
        check_eq("t6_async_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("t6_async_cnt", 32'(bus.q_count), 32'd0);
        check_eq("t6_async_addr", 32'(bus.im_addr), 32'(RESET_PC));
        for (int i = 0; i < 256; i++) rom[i] = INSTR_W'($urandom);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            next_cycle();
            bus.instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 29) == 0) bus.halt = ~bus.halt;
            bus.jump_en   = ($urandom_range(0, 24) == 0);
            bus.jump_addr = ADDR_W'($urandom);
        end
        next_cycle();
        bus.jump_en     = 1'b0;
        bus.halt        = 1'b0;
        bus.instr_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
